pixel_fetch: RTL

- Read-side pixel pump between the framebuffer FIFO (pixel_clk read port, show-ahead) and the video output interface.
- Consumes raw timing (HS, VS, active flag) from the timing generator. Pops one 24-bit pixel per active pixel, frame-aligned.
- Re-emits timing delayed so it aligns with the RGB.
- Detects FIFO underrun and resynchronises to the next frame without desynchronising from the writer's pixel count.

---
 rtl/pixel_fetch_pkg.sv | 25 ++
 rtl/pixel_fetch_if.sv | 29 ++
 rtl/pixel_fetch_sync_fall_det.sv | 23 ++
 rtl/pixel_fetch.sv | 146 ++++++++++++++
 4 files changed

// File: rtl/pixel_fetch_pkg.sv
// Shared video types for the pixel fetch path.
// Build option: PIXEL_FETCH_UNDERRUN_MARK_EN paints starved pixels red instead of black.
package video_pkg;

  typedef logic [23:0] rgb_t;

  typedef enum logic [1:0] {
    WAIT_FILL  = 2'd0,
    WAIT_FRAME = 2'd1,
    STREAM     = 2'd2,
    DRAIN      = 2'd3
  } fetch_state_t;

  localparam rgb_t RGB_BLACK = 24'h000000;
  localparam rgb_t RGB_RED   = 24'hFF0000;

`ifdef PIXEL_FETCH_UNDERRUN_MARK_EN
  localparam logic UNDERRUN_MARK_EN = 1'b1;
`else
  localparam logic UNDERRUN_MARK_EN = 1'b0;
`endif

  localparam rgb_t UNDERRUN_COLOR = UNDERRUN_MARK_EN ? RGB_RED : RGB_BLACK;

endpackage

// File: rtl/pixel_fetch_if.sv
// FIFO read port, raw timing in and aligned video out, bundled for pixel_fetch.
// slave = the fetch block; master = FIFO/timing generator/display side.
interface pixel_fetch_if;
  import video_pkg::*;

  logic [31:0] fifo_rdata;
  logic        fifo_rempty;
  logic        fifo_walmost_full;
  logic        fifo_read;
  logic        t_hs;
  logic        t_vs;
  logic        t_active;
  logic        o_hs;
  logic        o_vs;
  logic        o_blank;
  rgb_t        o_rgb;
  logic        underrun;

  modport master (
    output fifo_rdata, fifo_rempty, fifo_walmost_full, t_hs, t_vs, t_active,
    input  fifo_read, o_hs, o_vs, o_blank, o_rgb, underrun
  );

  modport slave (
    input  fifo_rdata, fifo_rempty, fifo_walmost_full, t_hs, t_vs, t_active,
    output fifo_read, o_hs, o_vs, o_blank, o_rgb, underrun
  );

endinterface

// File: rtl/pixel_fetch_sync_fall_det.sv
// Falling-edge detector: previous level is registered (resets high), edge is
// reported combinationally in the same cycle the input goes low.
module sync_fall_det (
  input  logic i_clk,
  input  logic i_rst,
  input  logic i_d,
  output logic o_fall
);

  logic r_d;

  // previous-cycle level of the input
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_d <= 1'b1;
    end else begin
      r_d <= i_d;
    end
  end

  assign o_fall = r_d & ~i_d;

endmodule

// File: rtl/pixel_fetch.sv
// Pixel pump from show-ahead framebuffer FIFO to video out, frame-aligned, with underrun recovery.
// Build option: PIXEL_FETCH_UNDERRUN_MARK_EN (see video_pkg) selects the starved-pixel colour.
module pixel_fetch
  import video_pkg::*;
#(
  parameter int unsigned HDISP = 800,
  parameter int unsigned VDISP = 480,
  parameter int unsigned PIX_W = 24
) (
  input  logic         pixel_clk,
  input  logic         pixel_rst,
  pixel_fetch_if.slave bus
);

  localparam int unsigned      NPIX  = HDISP * VDISP;
  localparam int unsigned      CNT_W = $clog2(NPIX);
  localparam logic [CNT_W-1:0] LAST  = CNT_W'(NPIX - 1);
  localparam logic [CNT_W-1:0] ZERO  = {CNT_W{1'b0}};

  fetch_state_t     r_state;
  fetch_state_t     w_next_state;
  logic [CNT_W-1:0] r_cnt;
  logic [CNT_W-1:0] w_cnt_next;
  logic             r_underrun;
  logic             w_underrun_next;
  logic             r_hs;
  logic             r_vs;
  logic             r_blank;
  rgb_t             r_rgb;
  rgb_t             w_rgb_next;
  rgb_t             w_head;
  logic             w_fs;
  logic             w_pop;
  logic             w_starve;
  logic             w_short;
  logic             w_unused_hi;

  sync_fall_det u_vs_fall (
    .i_clk  (pixel_clk),
    .i_rst  (pixel_rst),
    .i_d    (bus.t_vs),
    .o_fall (w_fs)
  );

  assign w_head      = rgb_t'(bus.fifo_rdata[PIX_W-1:0]);
  assign w_unused_hi = ^bus.fifo_rdata;

  // state register
  always_ff @(posedge pixel_clk or posedge pixel_rst) begin
    if (pixel_rst) begin
      r_state <= WAIT_FILL;
    end else begin
      r_state <= w_next_state;
    end
  end

  // next state, pop strobe and next-cycle pixel/counter values
  always_comb begin
    w_next_state    = r_state;
    w_cnt_next      = r_cnt;
    w_rgb_next      = RGB_BLACK;
    w_underrun_next = r_underrun;
    w_pop           = 1'b0;
    w_starve        = 1'b0;
    w_short         = 1'b0;
    case (r_state)
      WAIT_FILL: begin
        if (bus.fifo_walmost_full) begin
          w_next_state = WAIT_FRAME;
        end else begin
          w_next_state = WAIT_FILL;
        end
      end
      WAIT_FRAME: begin
        if (w_fs) begin
          w_next_state = STREAM;
        end else begin
          w_next_state = WAIT_FRAME;
        end
      end
      STREAM: begin
        w_pop    = bus.t_active & ~bus.fifo_rempty;
        w_starve = bus.t_active & bus.fifo_rempty;
        // a frame start before the counter wrapped means the timing source cut the frame short
        w_short  = w_fs & (r_cnt != ZERO);
        if (w_pop) begin
          w_rgb_next = w_head;
          w_cnt_next = (r_cnt == LAST) ? ZERO : r_cnt + 1'b1;
        end else if (w_starve) begin
          w_rgb_next = UNDERRUN_COLOR;
        end else begin
          w_rgb_next = RGB_BLACK;
        end
        if (w_starve | w_short) begin
          w_next_state    = DRAIN;
          w_underrun_next = 1'b1;
        end else begin
          w_next_state    = STREAM;
        end
      end
      DRAIN: begin
        // keep counting the writer's words so the next frame starts on its first word
        w_pop      = ~bus.fifo_rempty;
        w_rgb_next = bus.t_active ? UNDERRUN_COLOR : RGB_BLACK;
        if (w_pop && (r_cnt == LAST)) begin
          w_cnt_next   = ZERO;
          w_next_state = WAIT_FRAME;
        end else if (w_pop) begin
          w_cnt_next   = r_cnt + 1'b1;
        end else begin
          w_cnt_next   = r_cnt;
        end
      end
      default: begin
        w_next_state = WAIT_FILL;
      end
    endcase
  end

  // pop counter, sticky flag and the one-cycle-delayed video outputs
  always_ff @(posedge pixel_clk or posedge pixel_rst) begin
    if (pixel_rst) begin
      r_cnt      <= ZERO;
      r_underrun <= 1'b0;
      r_hs       <= 1'b1;
      r_vs       <= 1'b1;
      r_blank    <= 1'b0;
      r_rgb      <= RGB_BLACK;
    end else begin
      r_cnt      <= w_cnt_next;
      r_underrun <= w_underrun_next;
      r_hs       <= bus.t_hs;
      r_vs       <= bus.t_vs;
      r_blank    <= bus.t_active;
      r_rgb      <= w_rgb_next;
    end
  end

  assign bus.fifo_read = w_pop;
  assign bus.o_hs      = r_hs;
  assign bus.o_vs      = r_vs;
  assign bus.o_blank   = r_blank;
  assign bus.o_rgb     = r_rgb;
  assign bus.underrun  = r_underrun;

endmodule
